alu_issue_ctrl: RTL and testbench

//  Driver side of the ALU interface: ID/EX + EX/MEM pipeline wrapper around the combinational ALU.

---
 rtl/alu_issue_ctrl_pkg.sv | 37 +++
 rtl/alu_issue_ctrl_if.sv | 46 ++++
 rtl/alu_issue_ctrl_decode.sv | 33 +++
 rtl/alu_issue_ctrl.sv | 130 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants and types for the ALU issue controller.
// Contents: ex_cmd encodings, ALUOp codes, R-type funct codes, stage-1 control payload.
package alu_ctrl_pkg;

    localparam int unsigned CMD_W   = 5;
    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned FUNCT_W = 6;

    // ex_cmd encodings seen by the ALU
    localparam logic [CMD_W-1:0] CMD_AND = 5'd0;
    localparam logic [CMD_W-1:0] CMD_OR  = 5'd1;
    localparam logic [CMD_W-1:0] CMD_ADD = 5'd2;
    localparam logic [CMD_W-1:0] CMD_SUB = 5'd6;
    localparam logic [CMD_W-1:0] CMD_SLT = 5'd7;

    // ALUOp codes coming from ID (code 3 is reserved and decodes as add)
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'd0;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'd1;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'd2;

    // R-type function field values
    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'h20;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'h22;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'h24;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'h25;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'h2A;

    // Decoded control captured into stage 1 alongside the operands
    typedef struct packed {
        logic [CMD_W-1:0]   cmd;
        logic [ALUOP_W-1:0] aluop;
        logic               branch;
        logic               regwrite;
        logic               alusrc;
    } s1_ctrl_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Handshake/payload bundle between ID, the issue controller and the EX/MEM consumer.
// master: the environment (ID producer + downstream consumer); slave: alu_issue_ctrl.
// ID side: id_valid/id_ready plus decoded operands and indices; flush kills stage 1.
// EX side: ex_valid/ex_ready plus result, rd, regwrite; branch_taken and illegal_op pulses.
interface alu_issue_ctrl_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
);
    import alu_ctrl_pkg::*;

    logic                 id_valid;
    logic                 id_ready;
    logic [DW-1:0]        id_rs_val;
    logic [DW-1:0]        id_rt_val;
    logic [DW-1:0]        id_imm;
    logic [RW-1:0]        id_rs;
    logic [RW-1:0]        id_rt;
    logic [RW-1:0]        id_rd;
    logic                 id_regwrite;
    logic                 id_alusrc;
    logic [ALUOP_W-1:0]   id_aluop;
    logic [FUNCT_W-1:0]   id_funct;
    logic                 id_branch;
    logic                 flush;

    logic                 ex_valid;
    logic                 ex_ready;
    logic [DW-1:0]        ex_result;
    logic [RW-1:0]        ex_rd;
    logic                 ex_regwrite;
    logic                 branch_taken;
    logic                 illegal_op;

    modport master (
        output id_valid, id_rs_val, id_rt_val, id_imm, id_rs, id_rt, id_rd,
               id_regwrite, id_alusrc, id_aluop, id_funct, id_branch, flush, ex_ready,
        input  id_ready, ex_valid, ex_result, ex_rd, ex_regwrite, branch_taken, illegal_op
    );

    modport slave (
        input  id_valid, id_rs_val, id_rt_val, id_imm, id_rs, id_rt, id_rd,
               id_regwrite, id_alusrc, id_aluop, id_funct, id_branch, flush, ex_ready,
        output id_ready, ex_valid, ex_result, ex_rd, ex_regwrite, branch_taken, illegal_op
    );

endinterface

// File: rtl/alu_issue_ctrl_decode.sv
// ALU-control decode: maps ALUOp and the R-type funct field onto an ex_cmd.
// Ports: aluop, funct in; cmd_c (ex_cmd), illegal_c (unknown R-type funct) out, combinational.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [FUNCT_W-1:0] funct,
    output logic [CMD_W-1:0]   cmd_c,
    output logic               illegal_c
);

    always_comb begin
        cmd_c     = CMD_ADD;
        illegal_c = 1'b0;
        case (aluop)
            ALUOP_ADD: cmd_c = CMD_ADD;
            ALUOP_SUB: cmd_c = CMD_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: cmd_c = CMD_ADD;
                    FUNCT_SUB: cmd_c = CMD_SUB;
                    FUNCT_AND: cmd_c = CMD_AND;
                    FUNCT_OR:  cmd_c = CMD_OR;
                    FUNCT_SLT: cmd_c = CMD_SLT;
                    // unknown funct still executes as add, but is flagged
                    default:   illegal_c = 1'b1;
                endcase
            end
            default: cmd_c = CMD_ADD;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ID/EX + EX/MEM wrapper around an external combinational ALU.
// Stage 1 registers the decoded op and drives the ALU; stage 2 captures alu_out.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   io (slave)          ID handshake/operands, flush, EX handshake/result, pulses
//   input1, input2      ALU operands (stage-1 values with one-level forwarding from stage 2)
//   flag                stage-1 valid
//   ex_cmd, ALUOp       decoded ALU command and registered ALUOp
//   branchD             registered branch flag
//   alu_out             ALU result for the op in stage 1
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
)(
    input  logic                clk,
    input  logic                reset,
    alu_issue_ctrl_if.slave     io,
    output logic [DW-1:0]       input1,
    output logic [DW-1:0]       input2,
    output logic                flag,
    output logic [CMD_W-1:0]    ex_cmd,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                branchD,
    input  logic [DW-1:0]       alu_out
);

    logic              s1_valid;
    logic [DW-1:0]     s1_rs_val;
    logic [DW-1:0]     s1_op2;
    logic [RW-1:0]     s1_rs;
    logic [RW-1:0]     s1_rt;
    logic [RW-1:0]     s1_rd;
    s1_ctrl_t          s1_ctrl;

    logic              s2_valid;
    logic              s2_taken;

    logic [CMD_W-1:0]  dec_cmd;
    logic              dec_illegal;
    logic              load;
    logic              s2_adv;
    logic              s2_move;
    logic              fwd1;
    logic              fwd2;

    alu_ctrl_decode u_decode (
        .aluop     (io.id_aluop),
        .funct     (io.id_funct),
        .cmd_c     (dec_cmd),
        .illegal_c (dec_illegal)
    );

    // Handshake; a flushed stage-1 op must not slip into stage 2 on the same edge
    assign s2_adv      = s1_valid & (~s2_valid | io.ex_ready);
    assign s2_move     = s2_adv & ~io.flush;
    assign io.id_ready = ~s1_valid | s2_adv;
    assign load        = io.id_valid & io.id_ready;

    // Stage 1 (ID/EX); operand 2 is resolved between imm and rt at load
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            s1_rs_val     <= '0;
            s1_op2        <= '0;
            s1_rs         <= '0;
            s1_rt         <= '0;
            s1_rd         <= '0;
            s1_ctrl       <= '0;
            io.illegal_op <= 1'b0;
        end else begin
            io.illegal_op <= load & dec_illegal;
            if (io.flush) begin
                s1_valid <= 1'b0;
            end else if (load) begin
                s1_valid <= 1'b1;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end
            if (load) begin
                s1_rs_val        <= io.id_rs_val;
                s1_op2           <= io.id_alusrc ? io.id_imm : io.id_rt_val;
                s1_rs            <= io.id_rs;
                s1_rt            <= io.id_rt;
                s1_rd            <= io.id_rd;
                s1_ctrl.cmd      <= dec_cmd;
                s1_ctrl.aluop    <= io.id_aluop;
                s1_ctrl.branch   <= io.id_branch;
                s1_ctrl.regwrite <= io.id_regwrite;
                s1_ctrl.alusrc   <= io.id_alusrc;
            end
        end
    end

    // Stage 2 (EX/MEM); holds under backpressure, empties after a transfer with nothing behind it
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid       <= 1'b0;
            s2_taken       <= 1'b0;
            io.ex_result   <= '0;
            io.ex_rd       <= '0;
            io.ex_regwrite <= 1'b0;
        end else if (s2_move) begin
            s2_valid       <= 1'b1;
            s2_taken       <= s1_ctrl.branch & (alu_out == '0);
            io.ex_result   <= alu_out;
            io.ex_rd       <= s1_rd;
            io.ex_regwrite <= s1_ctrl.regwrite & ~s1_ctrl.branch;
        end else if (io.ex_ready) begin
            s2_valid <= 1'b0;
        end
    end

    assign io.ex_valid     = s2_valid;
    assign io.branch_taken = s2_valid & s2_taken & io.ex_ready;

    // One-level forwarding from stage 2; ex_regwrite is already zero for branches
    assign fwd1 = s2_valid & io.ex_regwrite & (io.ex_rd != '0) & (io.ex_rd == s1_rs);
    assign fwd2 = s2_valid & io.ex_regwrite & (io.ex_rd != '0) & (io.ex_rd == s1_rt)
                & ~s1_ctrl.alusrc;

    assign input1  = fwd1 ? io.ex_result : s1_rs_val;
    assign input2  = fwd2 ? io.ex_result : s1_op2;
    assign flag    = s1_valid;
    assign ex_cmd  = s1_ctrl.cmd;
    assign ALUOp   = s1_ctrl.aluop;
    assign branchD = s1_ctrl.branch;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU.
module tb_alu_issue_ctrl;
    import alu_ctrl_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic [DW-1:0]       input1;
    logic [DW-1:0]       input2;
    logic [DW-1:0]       alu_out;
    logic                flag;
    logic [CMD_W-1:0]    ex_cmd;
    logic [ALUOP_W-1:0]  ALUOp;
    logic                branchD;

    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.DW(DW), .RW(RW)) bus ();

    alu_issue_ctrl #(.DW(DW), .RW(RW)) dut (
        .clk     (clk),
        .reset   (reset),
        .io      (bus),
        .input1  (input1),
        .input2  (input2),
        .flag    (flag),
        .ex_cmd  (ex_cmd),
        .ALUOp   (ALUOp),
        .branchD (branchD),
        .alu_out (alu_out)
    );

    // Reference ALU
    always_comb begin
        alu_out = '0;
        case (ex_cmd)
            CMD_AND: alu_out = input1 & input2;
            CMD_OR:  alu_out = input1 | input2;
            CMD_ADD: alu_out = input1 + input2;
            CMD_SUB: alu_out = input1 - input2;
            CMD_SLT: alu_out = ($signed(input1) < $signed(input2)) ? 32'd1 : 32'd0;
            default: alu_out = '0;
        endcase
    end

    typedef struct {
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic        branch;
        logic        alusrc;
        logic        regwrite;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  exp_cmd;
        logic [31:0] exp_res;
        logic        exp_ill;
        logic        exp_taken;
        logic        exp_rw;
    } vec_t;

    vec_t vecs[12];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic [1:0] aluop, input logic [5:0] funct,
                                input logic branch, input logic alusrc, input logic regwrite,
                                input logic [31:0] rs_val, input logic [31:0] rt_val,
                                input logic [31:0] imm, input logic [4:0] rd,
                                input logic [4:0] exp_cmd, input logic [31:0] exp_res,
                                input logic exp_ill, input logic exp_taken, input logic exp_rw);
        vec_t v;
        v.aluop = aluop; v.funct = funct; v.branch = branch; v.alusrc = alusrc;
        v.regwrite = regwrite; v.rs_val = rs_val; v.rt_val = rt_val; v.imm = imm;
        v.rd = rd; v.exp_cmd = exp_cmd; v.exp_res = exp_res; v.exp_ill = exp_ill;
        v.exp_taken = exp_taken; v.exp_rw = exp_rw;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_op(input vec_t v, input logic [4:0] rs, input logic [4:0] rt);
        bus.id_valid    = 1'b1;
        bus.id_aluop    = v.aluop;
        bus.id_funct    = v.funct;
        bus.id_branch   = v.branch;
        bus.id_alusrc   = v.alusrc;
        bus.id_regwrite = v.regwrite;
        bus.id_rs_val   = v.rs_val;
        bus.id_rt_val   = v.rt_val;
        bus.id_imm      = v.imm;
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.id_rd       = v.rd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t pv[3];
        int   issued;
        int   got;
        logic [31:0] exp_q[3];

        bus.id_valid = 1'b0; bus.id_rs_val = '0; bus.id_rt_val = '0; bus.id_imm = '0;
        bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0; bus.id_regwrite = 1'b0;
        bus.id_alusrc = 1'b0; bus.id_aluop = '0; bus.id_funct = '0; bus.id_branch = 1'b0;
        bus.flush = 1'b0; bus.ex_ready = 1'b1;
        reset = 1'b1;

        //            aluop funct  br as rw  rs_val        rt_val        imm           rd  cmd      result        il tk rw
        vecs[0]  = mk(2'd2, 6'h20, 0, 0, 1, 32'd1,        32'd4,        32'd0,        3, CMD_ADD, 32'd5,        0, 0, 1);
        vecs[1]  = mk(2'd2, 6'h22, 0, 0, 1, 32'd10,       32'd3,        32'd0,        3, CMD_SUB, 32'd7,        0, 0, 1);
        vecs[2]  = mk(2'd2, 6'h24, 0, 0, 1, 32'hF0F0,     32'hFF00,     32'd0,        3, CMD_AND, 32'hF000,     0, 0, 1);
        vecs[3]  = mk(2'd2, 6'h25, 0, 0, 1, 32'hF0F0,     32'h0F00,     32'd0,        3, CMD_OR,  32'hFFF0,     0, 0, 1);
        vecs[4]  = mk(2'd2, 6'h2A, 0, 0, 1, 32'hFFFFFFFF, 32'd2,        32'd0,        3, CMD_SLT, 32'd1,        0, 0, 1);
        vecs[5]  = mk(2'd2, 6'h2A, 0, 0, 1, 32'd5,        32'd2,        32'd0,        3, CMD_SLT, 32'd0,        0, 0, 1);
        vecs[6]  = mk(2'd0, 6'h00, 0, 1, 1, 32'd100,      32'd0,        32'hFFFFFFFC, 5, CMD_ADD, 32'd96,       0, 0, 1);
        vecs[7]  = mk(2'd3, 6'h00, 0, 0, 1, 32'd7,        32'd8,        32'd0,        3, CMD_ADD, 32'd15,       0, 0, 1);
        vecs[8]  = mk(2'd1, 6'h00, 1, 0, 1, 32'd7,        32'd7,        32'd0,        0, CMD_SUB, 32'd0,        0, 1, 0);
        vecs[9]  = mk(2'd1, 6'h00, 1, 0, 1, 32'd7,        32'd8,        32'd0,        0, CMD_SUB, 32'hFFFFFFFF, 0, 0, 0);
        vecs[10] = mk(2'd2, 6'h3F, 0, 0, 1, 32'd2,        32'd3,        32'd0,        3, CMD_ADD, 32'd5,        1, 0, 1);
        vecs[11] = mk(2'd1, 6'h00, 0, 0, 1, 32'd20,       32'd5,        32'd0,        3, CMD_SUB, 32'd15,       0, 0, 1);

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst flag", 32'(flag), 32'd0);
        chk("rst ex_cmd", 32'(ex_cmd), 32'd0);
        chk("rst ALUOp", 32'(ALUOp), 32'd0);
        chk("rst id_ready", 32'(bus.id_ready), 32'd1);
        chk("rst illegal_op", 32'(bus.illegal_op), 32'd0);
        chk("rst ex_result", bus.ex_result, 32'd0);

        // Isolated ops through the table
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive_op(vecs[i], 5'd1, 5'd2);
            #1 chk($sformatf("v%0d id_ready", i), 32'(bus.id_ready), 32'd1);
            @(negedge clk);
            bus.id_valid = 1'b0;
            #1;
            chk($sformatf("v%0d flag", i), 32'(flag), 32'd1);
            chk($sformatf("v%0d ex_cmd", i), 32'(ex_cmd), 32'(vecs[i].exp_cmd));
            chk($sformatf("v%0d ALUOp", i), 32'(ALUOp), 32'(vecs[i].aluop));
            chk($sformatf("v%0d branchD", i), 32'(branchD), 32'(vecs[i].branch));
            chk($sformatf("v%0d illegal", i), 32'(bus.illegal_op), 32'(vecs[i].exp_ill));
            chk($sformatf("v%0d input1", i), input1, vecs[i].rs_val);
            chk($sformatf("v%0d input2", i), input2,
                vecs[i].alusrc ? vecs[i].imm : vecs[i].rt_val);
            chk($sformatf("v%0d early ex_valid", i), 32'(bus.ex_valid), 32'd0);
            @(negedge clk);
            #1;
            chk($sformatf("v%0d ex_valid", i), 32'(bus.ex_valid), 32'd1);
            chk($sformatf("v%0d ex_result", i), bus.ex_result, vecs[i].exp_res);
            chk($sformatf("v%0d ex_rd", i), 32'(bus.ex_rd), 32'(vecs[i].rd));
            chk($sformatf("v%0d ex_regwrite", i), 32'(bus.ex_regwrite), 32'(vecs[i].exp_rw));
            chk($sformatf("v%0d branch_taken", i), 32'(bus.branch_taken), 32'(vecs[i].exp_taken));
            chk($sformatf("v%0d illegal clr", i), 32'(bus.illegal_op), 32'd0);
            @(negedge clk);
            #1;
            chk($sformatf("v%0d drained", i), 32'(bus.ex_valid), 32'd0);
            chk($sformatf("v%0d taken clr", i), 32'(bus.branch_taken), 32'd0);
        end

        // Forwarding: A(rd3=1+4) -> B(rs3+imm10) -> C(rt4 from B) -> D(rd0) -> E(rs0, no forward)
        @(negedge clk);
        drive_op(mk(2'd2, 6'h20, 0, 0, 1, 32'd1, 32'd4, 32'd0, 3, 0, 0, 0, 0, 0), 5'd1, 5'd2);
        @(negedge clk);
        drive_op(mk(2'd0, 6'h00, 0, 1, 1, 32'd99, 32'd0, 32'd10, 4, 0, 0, 0, 0, 0), 5'd3, 5'd5);
        #1 chk("fwd B accept", 32'(bus.id_ready), 32'd1);
        @(negedge clk);
        drive_op(mk(2'd2, 6'h20, 0, 0, 1, 32'd1, 32'd0, 32'd0, 6, 0, 0, 0, 0, 0), 5'd1, 5'd4);
        #1;
        chk("fwd A result", bus.ex_result, 32'd5);
        chk("fwd B input1", input1, 32'd5);
        chk("fwd B input2 imm", input2, 32'd10);
        @(negedge clk);
        drive_op(mk(2'd2, 6'h20, 0, 0, 1, 32'd40, 32'd2, 32'd0, 0, 0, 0, 0, 0, 0), 5'd1, 5'd2);
        #1;
        chk("fwd B result", bus.ex_result, 32'd15);
        chk("fwd B rd", 32'(bus.ex_rd), 32'd4);
        chk("fwd C input1", input1, 32'd1);
        chk("fwd C input2", input2, 32'd15);
        @(negedge clk);
        drive_op(mk(2'd0, 6'h00, 0, 1, 1, 32'd7, 32'd0, 32'd1, 7, 0, 0, 0, 0, 0), 5'd0, 5'd0);
        #1 chk("fwd C result", bus.ex_result, 32'd16);
        @(negedge clk);
        bus.id_valid = 1'b0;
        #1;
        chk("fwd D result", bus.ex_result, 32'd42);
        chk("fwd E rd0 no-fwd", input1, 32'd7);
        @(negedge clk);
        #1 chk("fwd E result", bus.ex_result, 32'd8);
        repeat (2) @(negedge clk);

        // Backpressure: 3 ops, ex_ready low for the first 4 cycles
        pv[0] = mk(2'd0, 6'h00, 0, 1, 1, 32'd10, 32'd0, 32'd1, 8,  0, 0, 0, 0, 0);
        pv[1] = mk(2'd0, 6'h00, 0, 1, 1, 32'd20, 32'd0, 32'd2, 9,  0, 0, 0, 0, 0);
        pv[2] = mk(2'd0, 6'h00, 0, 1, 1, 32'd30, 32'd0, 32'd3, 10, 0, 0, 0, 0, 0);
        exp_q[0] = 32'd11; exp_q[1] = 32'd22; exp_q[2] = 32'd33;
        issued = 0;
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
            @(negedge clk);
            bus.ex_ready = (cyc >= 4);
            if (issued < 3) drive_op(pv[issued], 5'd20, 5'd21);
            else bus.id_valid = 1'b0;
            #1;
            if (cyc == 2 || cyc == 3) begin
                chk($sformatf("bp c%0d id_ready", cyc), 32'(bus.id_ready), 32'd0);
                chk($sformatf("bp c%0d ex_result", cyc), bus.ex_result, 32'd11);
                chk($sformatf("bp c%0d input1", cyc), input1, 32'd20);
            end
            if (bus.ex_valid && bus.ex_ready) begin
                chk($sformatf("bp out%0d", got), bus.ex_result, exp_q[got]);
                got++;
            end
            if (bus.id_valid && bus.id_ready) issued++;
        end
        chk("bp count", 32'(got), 32'd3);
        @(negedge clk);
        bus.id_valid = 1'b0;
        #1 chk("bp no dup", 32'(bus.ex_valid), 32'd0);

        // Illegal funct then flush while it sits in stage 1
        @(negedge clk);
        drive_op(mk(2'd2, 6'h3F, 0, 0, 1, 32'd2, 32'd3, 32'd0, 3, 0, 0, 0, 0, 0), 5'd1, 5'd2);
        @(negedge clk);
        bus.id_valid = 1'b0;
        bus.flush = 1'b1;
        #1;
        chk("ill pulse", 32'(bus.illegal_op), 32'd1);
        chk("ill ex_cmd", 32'(ex_cmd), 32'(CMD_ADD));
        chk("ill flag", 32'(flag), 32'd1);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        chk("flush flag", 32'(flag), 32'd0);
        chk("flush ill clr", 32'(bus.illegal_op), 32'd0);
        chk("flush ex_valid", 32'(bus.ex_valid), 32'd0);
        @(negedge clk);
        #1 chk("flush ex_valid2", 32'(bus.ex_valid), 32'd0);

        // Flush in the same cycle as a load kills the loading op
        @(negedge clk);
        drive_op(mk(2'd0, 6'h00, 0, 1, 1, 32'd5, 32'd0, 32'd5, 3, 0, 0, 0, 0, 0), 5'd1, 5'd2);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.id_valid = 1'b0;
        bus.flush = 1'b0;
        #1 chk("flush-load flag", 32'(flag), 32'd0);
        @(negedge clk);
        #1 chk("flush-load ex_valid", 32'(bus.ex_valid), 32'd0);

        // Flush never retracts a result already in stage 2
        @(negedge clk);
        drive_op(mk(2'd0, 6'h00, 0, 1, 1, 32'd50, 32'd0, 32'd6, 3, 0, 0, 0, 0, 0), 5'd1, 5'd2);
        bus.ex_ready = 1'b0;
        @(negedge clk);
        bus.id_valid = 1'b0;
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        chk("s2 kept ex_valid", 32'(bus.ex_valid), 32'd1);
        chk("s2 kept ex_result", bus.ex_result, 32'd56);
        bus.ex_ready = 1'b1;
        @(negedge clk);
        #1 chk("s2 drained", 32'(bus.ex_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
